intersection_traffic_model: RTL and testbench
=============================================

Name: intersection_traffic_model

Overview:
- Vehicle-side model of the intersection. It sits at the opposite end of the sensor/light interface from traffic_light_controller.
- Consumes the five light outputs and produces the five sensor inputs.
- Per lane: holds a saturating vehicle queue fed by arrival pulses and drains one vehicle per DEPART_CYCLES cycles of green.
- Also acts as a sticky hardware safety monitor, flagging conflicting greens/yellows, green-to-red without yellow, starvation and queue overflow.

Parameters:
- QUEUE_W, 4, width of each lane queue counter; max count 2**QUEUE_W-1.
- DEPART_CYCLES, 2, consecutive green cycles needed per departing vehicle (>=1).
- STARVE_CYCLES, 64, waiting cycles (queue non-empty, light not green) before starve flag.
- STARVE_W, 8, width of starvation counters; must hold STARVE_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- arrive  in  5  one vehicle arrival per set bit per cycle; lane index 0=e_left, 1=e_str, 2=w_left, 3=w_str, 4=ns.
- e_left_light, e_str_light, w_left_light, w_str_light, ns_light  in  2 each  light_package colors (red/yellow/green).
- e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor  out  1 each  lane queue non-empty.
- q_count  out  5*QUEUE_W  packed lane counts, lane i at [i*QUEUE_W +: QUEUE_W].
- depart  out  5  one-cycle pulse per lane when a vehicle leaves.
- clr_err  in  1  synchronous clear of all sticky flags.
- conflict_err  out  1  sticky, incompatible lights non-red.
- encode_err  out  1  sticky, light value not red/yellow/green.
- skip_err  out  5  sticky per lane, green followed directly by red.
- starve_err  out  5  sticky per lane.
- overflow_err  out  5  sticky per lane, arrival dropped at full queue.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counts, timers, wait counters and flags go to 0.
  - depart=0 and sensors=0.
  - The previous-light registers load red.
- Sensor: lane sensor = (count != 0), driven from the count register, so it is glitch-free. It deasserts the cycle after the last departure edge.
- Departure timer per lane, 0..DEPART_CYCLES-1:
  - Counts when light==green and count>0. Otherwise it is held at 0.
  - depart[i] is asserted combinationally while light==green, count>0 and timer==DEPART_CYCLES-1.
  - At that edge the count decrements and the timer returns to 0.
  - With DEPART_CYCLES=1, the lane drains one vehicle per green cycle.
  - Yellow and red never depart.
- Count update per edge is count + arrive - depart:
  - Arrive and depart in the same cycle leaves the count unchanged, including at full.
  - Arrival without departure at max leaves the count at max and sets overflow_err[i].
  - Count never wraps, and never decrements below 0 (depart requires count>0).
- Starvation counter per lane:
  - Increments each cycle with count>0 and light!=green, saturating at 2**STARVE_W-1.
  - Clears when light==green or count==0.
  - starve_err[i] sets on the edge where the counter reaches STARVE_CYCLES.
- Conflict check, evaluated on the current inputs each cycle and registered:
  - Checked pairs (non-red = yellow or green): e_left vs w_str; e_left vs ns; w_left vs e_str; w_left vs ns; ns vs e_str; ns vs w_str.
  - Any checked pair both non-red sets conflict_err at the next edge.
  - Allowed combinations: e_left+w_left, e_str+w_str, e_left+e_str, w_left+w_str.
- encode_err: any input equal to an undefined 2-bit code sets encode_err at the next edge. That lane is treated as red for departures.
- Sequence check: a prev_light register per lane. prev==green and current==red sets skip_err[i] at the next edge. green->yellow, yellow->red and red->green are legal.
- Sticky flags:
  - Once set, flags hold until clr_err or reset.
  - If clr_err coincides with a new violation, set wins.
  - clr_err does not affect counts or timers.
- Reset mid-operation: queues empty immediately and all flags clear. The first post-reset sample compares against prev=red.

Test Plan:
- Reset, then arrive[0] for 3 cycles with all lights red -> q_count lane0 = 3; e_left_sensor rises 1 cycle after the first arrival; no depart; no flags.
- Lane0 holds 3 vehicles, e_left_light green for 6 cycles with DEPART_CYCLES=2 -> depart[0] pulses on green cycles 2, 4 and 6; count 3->0; sensor low after the 6th edge.
- ns_light green and e_str_light yellow in the same cycle -> conflict_err=1 next edge, stays 1; clr_err for one cycle -> 0. Then e_left+w_left green together -> conflict_err stays 0.
- 16 arrivals to lane4 with QUEUE_W=4 and ns red -> count saturates at 15, overflow_err[4]=1. Then arrive+depart in one cycle at 15 under green -> count stays 15.
- Lane1 non-empty with e_str_light red for 64 cycles, STARVE_CYCLES=64 -> starve_err[1] sets on edge 64, not 63. A green on cycle 30 instead -> counter restarts and no flag.
- w_str_light green->red directly -> skip_err[3]=1. green->yellow->red -> no flag. Assert reset mid-queue with count=5 -> count 0 and all flags 0 asynchronously.

Source files
------------

// File: rtl/intersection_traffic_model.sv
// rtl/intersection_traffic_model.sv - vehicle-side intersection model with lane queues and safety monitor
// Light codes: 0=red, 1=yellow, 2=green, 3=undefined. Lanes: 0=e_left 1=e_str 2=w_left 3=w_str 4=ns.
module intersection_traffic_model #(
  parameter int QUEUE_W       = 4,
  parameter int DEPART_CYCLES = 2,
  parameter int STARVE_CYCLES = 64,
  parameter int STARVE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           arrive,
  input  logic [1:0]           e_left_light,
  input  logic [1:0]           e_str_light,
  input  logic [1:0]           w_left_light,
  input  logic [1:0]           w_str_light,
  input  logic [1:0]           ns_light,
  output logic                 e_left_sensor,
  output logic                 e_str_sensor,
  output logic                 w_left_sensor,
  output logic                 w_str_sensor,
  output logic                 ns_sensor,
  output logic [5*QUEUE_W-1:0] q_count,
  output logic [4:0]           depart,
  input  logic                 clr_err,
  output logic                 conflict_err,
  output logic                 encode_err,
  output logic [4:0]           skip_err,
  output logic [4:0]           starve_err,
  output logic [4:0]           overflow_err
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BADCODE = 2'd3;
  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [QUEUE_W-1:0]  QMAX  = '1;
  localparam logic [TW-1:0]       TLAST = TW'(DEPART_CYCLES - 1);
  localparam logic [STARVE_W-1:0] SMAX  = '1;
  localparam logic [STARVE_W-1:0] SLAST = STARVE_W'(STARVE_CYCLES - 1);

  logic [1:0]          light    [5];
  logic [1:0]          prev     [5];
  logic [QUEUE_W-1:0]  count    [5];
  logic [TW-1:0]       timer    [5];
  logic [STARVE_W-1:0] wait_cnt [5];

  logic [4:0] green, busy, nonred, dep, skip_now, starve_now, ovf_now;
  logic       conflict_now, encode_now;

  assign light[0] = e_left_light;
  assign light[1] = e_str_light;
  assign light[2] = w_left_light;
  assign light[3] = w_str_light;
  assign light[4] = ns_light;

  always_comb begin
    green      = '0;
    busy       = '0;
    nonred     = '0;
    dep        = '0;
    skip_now   = '0;
    starve_now = '0;
    ovf_now    = '0;
    encode_now = 1'b0;
    q_count    = '0;
    for (int i = 0; i < 5; i++) begin
      green[i]      = (light[i] == GREEN);
      busy[i]       = (count[i] != '0);
      nonred[i]     = (light[i] == YELLOW) || (light[i] == GREEN);
      dep[i]        = green[i] && busy[i] && (timer[i] == TLAST);
      skip_now[i]   = (prev[i] == GREEN) && (light[i] == RED);
      starve_now[i] = busy[i] && !green[i] && (wait_cnt[i] == SLAST);
      ovf_now[i]    = arrive[i] && !dep[i] && (count[i] == QMAX);
      encode_now    = encode_now || (light[i] == BADCODE);
      q_count[i*QUEUE_W +: QUEUE_W] = count[i];
    end
    // Only crossing movements conflict; same-side and opposing lefts/straights may share green.
    conflict_now = (nonred[0] && nonred[3]) || (nonred[0] && nonred[4]) ||
                   (nonred[2] && nonred[1]) || (nonred[2] && nonred[4]) ||
                   (nonred[4] && nonred[1]) || (nonred[4] && nonred[3]);
  end

  assign depart        = dep;
  assign e_left_sensor = busy[0];
  assign e_str_sensor  = busy[1];
  assign w_left_sensor = busy[2];
  assign w_str_sensor  = busy[3];
  assign ns_sensor     = busy[4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        count[i]    <= '0;
        timer[i]    <= '0;
        wait_cnt[i] <= '0;
        prev[i]     <= RED;
      end
      conflict_err <= 1'b0;
      encode_err   <= 1'b0;
      skip_err     <= '0;
      starve_err   <= '0;
      overflow_err <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        case ({arrive[i], dep[i]})
          2'b10:   if (count[i] != QMAX) count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (green[i] && busy[i]) timer[i] <= dep[i] ? '0 : timer[i] + 1'b1;
        else                     timer[i] <= '0;
        if (busy[i] && !green[i]) wait_cnt[i] <= (wait_cnt[i] == SMAX) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
        else                      wait_cnt[i] <= '0;
        prev[i] <= light[i];
      end
      // A violation in the same cycle as clr_err still latches.
      conflict_err <= (conflict_err && !clr_err) || conflict_now;
      encode_err   <= (encode_err && !clr_err) || encode_now;
      skip_err     <= (skip_err & {5{!clr_err}}) | skip_now;
      starve_err   <= (starve_err & {5{!clr_err}}) | starve_now;
      overflow_err <= (overflow_err & {5{!clr_err}}) | ovf_now;
    end
  end

endmodule

// File: tb/tb_intersection_traffic_model.sv
// tb/tb_intersection_traffic_model.sv - directed bench with lane-level reference model
module tb_intersection_traffic_model;
  localparam int QW = 4, DEP = 2, SC = 64, SW = 8;
  localparam int QMAX = 15, SMAX = 255;
  localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2;

  logic         clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [4:0]   arrive = '0;
  logic [1:0]   L [5];
  logic         s_el, s_es, s_wl, s_ws, s_ns;
  logic [5*QW-1:0] q_count;
  logic [4:0]   depart, skip_err, starve_err, overflow_err;
  logic         conflict_err, encode_err;

  intersection_traffic_model #(.QUEUE_W(QW), .DEPART_CYCLES(DEP), .STARVE_CYCLES(SC), .STARVE_W(SW)) dut (
    .clk(clk), .reset(rst_n), .arrive(arrive),
    .e_left_light(L[0]), .e_str_light(L[1]), .w_left_light(L[2]), .w_str_light(L[3]), .ns_light(L[4]),
    .e_left_sensor(s_el), .e_str_sensor(s_es), .w_left_sensor(s_wl), .w_str_sensor(s_ws), .ns_sensor(s_ns),
    .q_count(q_count), .depart(depart), .clr_err(clr),
    .conflict_err(conflict_err), .encode_err(encode_err), .skip_err(skip_err),
    .starve_err(starve_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vehicles per lane, green cycles accrued toward the next departure, cycles waited.
  int         mc [5], mprog [5], mwait [5];
  logic [1:0] mprev [5];
  bit         mconf, menc;
  bit [4:0]   mskip, mstarve, movf;
  int pa [6] = '{0, 0, 2, 2, 4, 4};
  int pb [6] = '{3, 4, 1, 4, 1, 3};

  function automatic bit lit(input logic [1:0] c);
    return (c == Y) || (c == G);
  endfunction

  function automatic bit leaves(input int i);
    return (L[i] == G) && (mc[i] > 0) && (mprog[i] == DEP - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit [4:0] sk, st, ov;
    bit cn, en, g, d;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        mc[i] <= 0; mprog[i] <= 0; mwait[i] <= 0; mprev[i] <= R;
      end
      mconf <= 0; menc <= 0; mskip <= 0; mstarve <= 0; movf <= 0;
    end else begin
      sk = 0; st = 0; ov = 0; cn = 0; en = 0;
      for (int i = 0; i < 5; i++) begin
        g = (L[i] == G);
        d = leaves(i);
        if (arrive[i] && !d && mc[i] == QMAX) ov[i] = 1;
        mc[i]    <= (mc[i] + int'(arrive[i]) - int'(d) > QMAX) ? QMAX : mc[i] + int'(arrive[i]) - int'(d);
        mprog[i] <= (g && mc[i] > 0) ? (d ? 0 : mprog[i] + 1) : 0;
        if (mc[i] > 0 && !g) begin
          if (mwait[i] + 1 == SC) st[i] = 1;
          mwait[i] <= (mwait[i] == SMAX) ? SMAX : mwait[i] + 1;
        end else mwait[i] <= 0;
        if (mprev[i] == G && L[i] == R) sk[i] = 1;
        if (L[i] == 2'd3) en = 1;
        mprev[i] <= L[i];
      end
      for (int k = 0; k < 6; k++) if (lit(L[pa[k]]) && lit(L[pb[k]])) cn = 1;
      mconf   <= (mconf && !clr) || cn;
      menc    <= (menc && !clr) || en;
      mskip   <= (clr ? 5'b0 : mskip) | sk;
      mstarve <= (clr ? 5'b0 : mstarve) | st;
      movf    <= (clr ? 5'b0 : movf) | ov;
    end
  end

  always @(negedge clk) begin : compare
    logic [5*QW-1:0] eq;
    logic [4:0] ed, es;
    for (int i = 0; i < 5; i++) begin
      eq[i*QW +: QW] = QW'(mc[i]);
      ed[i] = leaves(i);
      es[i] = (mc[i] != 0);
    end
    chk("q_count", q_count, eq);
    chk("depart", depart, ed);
    chk("sensors", {s_ns, s_ws, s_wl, s_es, s_el}, es);
    chk("conflict_err", conflict_err, mconf);
    chk("encode_err", encode_err, menc);
    chk("skip_err", skip_err, mskip);
    chk("starve_err", starve_err, mstarve);
    chk("overflow_err", overflow_err, movf);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mask;
    for (int i = 0; i < 5; i++) L[i] = R;
    step(2);
    rst_n = 1'b1;
    chk("reset_q", q_count, 0);
    chk("reset_flags", {conflict_err, encode_err, skip_err, starve_err, overflow_err}, 0);
    step(1);

    arrive = 5'b00001;
    step(1);
    chk("sensor_rise", s_el, 1);
    step(2);
    arrive = 5'b0;
    chk("fill_lane0", q_count[3:0], 3);
    chk("no_depart_red", depart, 0);

    L[0] = G;
    mask = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (depart[0]) mask[k] = 1'b1;
      step(1);
    end
    chk("depart_cycles", mask, 8'b0101_0100);
    chk("drained_lane0", q_count[3:0], 0);
    chk("sensor_fall", s_el, 0);
    L[0] = Y; step(1); L[0] = R; step(1);

    L[4] = G; L[1] = Y; step(1);
    chk("conflict_set", conflict_err, 1);
    L[4] = Y; L[1] = R; step(1);
    L[4] = R; step(2);
    chk("conflict_sticky", conflict_err, 1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("conflict_clr", conflict_err, 0);
    L[0] = G; L[2] = G; step(2);
    chk("left_pair_ok", conflict_err, 0);
    L[0] = Y; L[2] = Y; step(1); L[0] = R; L[2] = R; step(1);
    L[4] = 2'd3; step(1);
    chk("encode_set", encode_err, 1);
    L[4] = R; clr = 1'b1; step(1); clr = 1'b0;

    arrive = 5'b10000; step(16); arrive = 5'b0;
    chk("saturate", q_count[19:16], 15);
    chk("overflow4", overflow_err[4], 1);
    L[4] = G; arrive = 5'b10000; step(1);
    @(negedge clk);
    chk("full_arrdep", depart[4], 1);
    step(1);
    chk("full_hold", q_count[19:16], 15);
    arrive = 5'b0; L[4] = Y; step(1); L[4] = R;
    clr = 1'b1; step(1); clr = 1'b0;

    arrive = 5'b00010; step(1); arrive = 5'b0;
    step(63);
    chk("starve_63", starve_err[1], 0);
    step(1);
    chk("starve_64", starve_err[1], 1);
    clr = 1'b1; L[1] = G; step(1); clr = 1'b0;
    L[1] = Y; step(1); L[1] = R; step(62);
    chk("starve_restart", starve_err[1], 0);

    L[3] = G; step(1); L[3] = R; step(1);
    chk("skip_set", skip_err[3], 1);
    clr = 1'b1; step(1); clr = 1'b0;
    L[3] = G; step(1); L[3] = Y; step(1); L[3] = R; step(2);
    chk("skip_legal", skip_err[3], 0);

    L[3] = G; step(1); L[3] = R;
    arrive = 5'b00001; step(5); arrive = 5'b0;
    chk("fill5", q_count[3:0], 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_q", q_count, 0);
    chk("async_flags", {conflict_err, encode_err, skip_err, starve_err, overflow_err}, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
